// File: rtl/control_unit_pkg.sv
// Shared definitions for the RV32I control unit: opcodes, decoded-instruction
// bit positions, ALU one-hot op encodings and the instruction class enum.
package control_unit_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam int unsigned BIT_ADD   = 0;
  localparam int unsigned BIT_AND   = 9;
  localparam int unsigned BIT_ADDI  = 10;
  localparam int unsigned BIT_SLTI  = 11;
  localparam int unsigned BIT_SLTIU = 12;
  localparam int unsigned BIT_XORI  = 13;
  localparam int unsigned BIT_ORI   = 14;
  localparam int unsigned BIT_ANDI  = 15;
  localparam int unsigned BIT_SLLI  = 16;
  localparam int unsigned BIT_SRLI  = 17;
  localparam int unsigned BIT_SRAI  = 18;
  localparam int unsigned BIT_LB    = 19;
  localparam int unsigned BIT_LH    = 20;
  localparam int unsigned BIT_LW    = 21;
  localparam int unsigned BIT_LBU   = 22;
  localparam int unsigned BIT_LHU   = 23;
  localparam int unsigned BIT_SB    = 24;
  localparam int unsigned BIT_SH    = 25;
  localparam int unsigned BIT_SW    = 26;
  localparam int unsigned BIT_BEQ   = 27;
  localparam int unsigned BIT_BNE   = 28;
  localparam int unsigned BIT_BLT   = 29;
  localparam int unsigned BIT_BGE   = 30;
  localparam int unsigned BIT_BLTU  = 31;
  localparam int unsigned BIT_BGEU  = 32;
  localparam int unsigned BIT_LUI   = 33;
  localparam int unsigned BIT_AUIPC = 34;
  localparam int unsigned BIT_JAL   = 35;
  localparam int unsigned BIT_JALR  = 36;

  localparam logic [9:0] ALU_ADD  = 10'h001;
  localparam logic [9:0] ALU_SUB  = 10'h002;
  localparam logic [9:0] ALU_SLL  = 10'h004;
  localparam logic [9:0] ALU_SLT  = 10'h008;
  localparam logic [9:0] ALU_SLTU = 10'h010;
  localparam logic [9:0] ALU_XOR  = 10'h020;
  localparam logic [9:0] ALU_SRL  = 10'h040;
  localparam logic [9:0] ALU_SRA  = 10'h080;
  localparam logic [9:0] ALU_OR   = 10'h100;
  localparam logic [9:0] ALU_AND  = 10'h200;

  typedef enum logic [3:0] {
    CLS_NONE, CLS_R, CLS_I, CLS_LOAD, CLS_STORE,
    CLS_BRANCH, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR
  } instr_class_e;

  // Keeps the ALU op strictly one-hot even if several decode bits are set.
  function automatic logic [9:0] first_one(input logic [9:0] v);
    logic [9:0] r;
    r = '0;
    for (int i = 9; i >= 0; i--)
      if (v[i]) r = 10'b1 << i;
    return r;
  endfunction

endpackage

// File: rtl/control_unit_branch_compare.sv
// Branch condition evaluation from the register operands; the six select
// bits are the beq..bgeu slice of the decoded instruction.
module branch_compare
  import control_unit_pkg::*;
(
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [5:0]  br_bits,
  output logic        taken
);

  always_comb begin
    taken = 1'b0;
    if      (br_bits[BIT_BEQ  - BIT_BEQ]) taken = (rs1 == rs2);
    else if (br_bits[BIT_BNE  - BIT_BEQ]) taken = (rs1 != rs2);
    else if (br_bits[BIT_BLT  - BIT_BEQ]) taken = ($signed(rs1) <  $signed(rs2));
    else if (br_bits[BIT_BGE  - BIT_BEQ]) taken = ($signed(rs1) >= $signed(rs2));
    else if (br_bits[BIT_BLTU - BIT_BEQ]) taken = (rs1 <  rs2);
    else if (br_bits[BIT_BGEU - BIT_BEQ]) taken = (rs1 >= rs2);
  end

endmodule

// File: rtl/control_unit.sv
// RV32I control unit: drives ALU operands/op combinationally and registers
// writeback, memory and PC-redirect results one cycle later.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [36:0] out_signal,
  input  logic [31:0] rs1_input,
  input  logic [31:0] rs2_input,
  input  logic [31:0] imm,
  input  logic [31:0] pc_input,
  input  logic [31:0] mem_read,
  input  logic [31:0] ALUoutput,
  output logic [9:0]  instructions,
  output logic [31:0] v1,
  output logic [31:0] v2,
  output logic [31:0] final_output,
  output logic [31:0] addr,
  output logic [31:0] mem_write,
  output logic        wr_en,
  output logic        j_signal,
  output logic [31:0] jump
);

  instr_class_e cls;
  logic         taken;
  logic [9:0]   imm_ops;
  logic [31:0]  nxt_final, nxt_addr, nxt_mem_write, nxt_jump;
  logic         nxt_wr_en, nxt_j;

  branch_compare u_branch_compare (
    .rs1     (rs1_input),
    .rs2     (rs2_input),
    .br_bits (out_signal[BIT_BGEU:BIT_BEQ]),
    .taken   (taken)
  );

  always_comb begin
    unique case (opcode)
      OPC_R:      cls = CLS_R;
      OPC_I:      cls = CLS_I;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      default:    cls = CLS_NONE;
    endcase
  end

  // Immediate ops rearranged into the ALU one-hot bit order.
  assign imm_ops = {out_signal[BIT_ANDI], out_signal[BIT_ORI], out_signal[BIT_SRAI],
                    out_signal[BIT_SRLI], out_signal[BIT_XORI], out_signal[BIT_SLTIU],
                    out_signal[BIT_SLTI], out_signal[BIT_SLLI], 1'b0, out_signal[BIT_ADDI]};

  always_comb begin
    instructions  = '0;
    v1            = '0;
    v2            = '0;
    nxt_final     = '0;
    nxt_addr      = '0;
    nxt_mem_write = '0;
    nxt_jump      = '0;
    nxt_wr_en     = 1'b0;
    nxt_j         = 1'b0;
    case (cls)
      CLS_R: if (|out_signal[BIT_AND:BIT_ADD]) begin
        instructions = first_one(out_signal[BIT_AND:BIT_ADD]);
        v1 = rs1_input;
        v2 = rs2_input;
        nxt_final = ALUoutput;
      end
      CLS_I: if (|imm_ops) begin
        instructions = first_one(imm_ops);
        v1 = rs1_input;
        v2 = imm;
        nxt_final = ALUoutput;
      end
      CLS_LOAD: if (|out_signal[BIT_LHU:BIT_LB]) begin
        instructions = ALU_ADD;
        v1 = rs1_input;
        v2 = imm;
        nxt_addr = ALUoutput;
        if      (out_signal[BIT_LB])  nxt_final = {{24{mem_read[7]}}, mem_read[7:0]};
        else if (out_signal[BIT_LH])  nxt_final = {{16{mem_read[15]}}, mem_read[15:0]};
        else if (out_signal[BIT_LW])  nxt_final = mem_read;
        else if (out_signal[BIT_LBU]) nxt_final = {24'b0, mem_read[7:0]};
        else                          nxt_final = {16'b0, mem_read[15:0]};
      end
      CLS_STORE: if (|out_signal[BIT_SW:BIT_SB]) begin
        instructions = ALU_ADD;
        v1 = rs1_input;
        v2 = imm;
        nxt_addr  = ALUoutput;
        nxt_wr_en = 1'b1;
        if      (out_signal[BIT_SB]) nxt_mem_write = {24'b0, rs2_input[7:0]};
        else if (out_signal[BIT_SH]) nxt_mem_write = {16'b0, rs2_input[15:0]};
        else                         nxt_mem_write = rs2_input;
      end
      CLS_BRANCH: if (|out_signal[BIT_BGEU:BIT_BEQ]) begin
        instructions = ALU_SUB;
        v1 = rs1_input;
        v2 = rs2_input;
        nxt_j    = taken;
        nxt_jump = taken ? pc_input + imm : 32'd0;
      end
      CLS_LUI: if (out_signal[BIT_LUI]) begin
        instructions = ALU_ADD;
        v2 = imm;
        nxt_final = ALUoutput;
      end
      CLS_AUIPC: if (out_signal[BIT_AUIPC]) begin
        instructions = ALU_ADD;
        v1 = pc_input;
        v2 = imm;
        nxt_final = ALUoutput;
      end
      CLS_JAL: if (out_signal[BIT_JAL]) begin
        instructions = ALU_ADD;
        v1 = pc_input;
        v2 = imm;
        nxt_final = pc_input + 32'd4;
        nxt_j     = 1'b1;
        nxt_jump  = pc_input + imm;
      end
      CLS_JALR: if (out_signal[BIT_JALR]) begin
        instructions = ALU_ADD;
        v1 = rs1_input;
        v2 = imm;
        nxt_final = pc_input + 32'd4;
        nxt_j     = 1'b1;
        nxt_jump  = (rs1_input + imm) & ~32'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      final_output <= '0;
      addr         <= '0;
      mem_write    <= '0;
      wr_en        <= 1'b0;
      j_signal     <= 1'b0;
      jump         <= '0;
    end else begin
      final_output <= nxt_final;
      addr         <= nxt_addr;
      mem_write    <= nxt_mem_write;
      wr_en        <= nxt_wr_en;
      j_signal     <= nxt_j;
      jump         <= nxt_jump;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit with hand-computed expectations.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  opcode = '0;
  logic [36:0] out_signal = '0;
  logic [31:0] rs1_input = '0, rs2_input = '0, imm = '0, pc_input = '0;
  logic [31:0] mem_read = '0, ALUoutput = '0;
  logic [9:0]  instructions;
  logic [31:0] v1, v2, final_output, addr, mem_write, jump;
  logic        wr_en, j_signal;

  int tests_run = 0;
  int tests_failed = 0;

  control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .out_signal(out_signal),
    .rs1_input(rs1_input), .rs2_input(rs2_input), .imm(imm), .pc_input(pc_input),
    .mem_read(mem_read), .ALUoutput(ALUoutput), .instructions(instructions),
    .v1(v1), .v2(v2), .final_output(final_output), .addr(addr),
    .mem_write(mem_write), .wr_en(wr_en), .j_signal(j_signal), .jump(jump)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Inputs change on the falling edge so the next rising edge samples them cleanly.
  task automatic apply_stimulus(input logic [6:0] opc, input int bit_idx,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] im, input logic [31:0] pc,
                                input logic [31:0] alu, input logic [31:0] mem);
    logic [36:0] os;
    @(negedge clk);
    os = '0;
    if (bit_idx >= 0) os[bit_idx] = 1'b1;
    opcode = opc; out_signal = os;
    rs1_input = rs1; rs2_input = rs2; imm = im; pc_input = pc;
    ALUoutput = alu; mem_read = mem;
    #1;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check_output("rst final_output", final_output, 32'd0);
    check_output("rst addr", addr, 32'd0);
    check_output("rst mem_write", mem_write, 32'd0);
    check_output("rst wr_en", {31'd0, wr_en}, 32'd0);
    check_output("rst j_signal", {31'd0, j_signal}, 32'd0);
    check_output("rst jump", jump, 32'd0);
    @(negedge clk) rst = 1'b0;

    apply_stimulus(7'b0110011, 0, 32'd13, 32'd13, 32'd0, 32'd0, 32'd26, 32'd0);
    check_output("add instructions", {22'd0, instructions}, 32'h001);
    check_output("add v1", v1, 32'd13);
    check_output("add v2", v2, 32'd13);
    next_edge();
    check_output("add final_output", final_output, 32'd26);
    check_output("add wr_en", {31'd0, wr_en}, 32'd0);
    check_output("add j_signal", {31'd0, j_signal}, 32'd0);

    apply_stimulus(7'b0000011, 21, 32'd13, 32'd0, 32'd1, 32'd0, 32'd14, 32'h3ffff);
    check_output("lw instructions", {22'd0, instructions}, 32'h001);
    check_output("lw v2", v2, 32'd1);
    next_edge();
    check_output("lw addr", addr, 32'd14);
    check_output("lw final_output", final_output, 32'h3ffff);

    apply_stimulus(7'b0000011, 19, 32'd13, 32'd0, 32'd1, 32'd0, 32'd14, 32'h80);
    next_edge();
    check_output("lb final_output", final_output, 32'hFFFFFF80);

    apply_stimulus(7'b0000011, 20, 32'd13, 32'd0, 32'd1, 32'd0, 32'd14, 32'hFFFF8001);
    next_edge();
    check_output("lh final_output", final_output, 32'hFFFF8001);

    apply_stimulus(7'b0000011, 23, 32'd13, 32'd0, 32'd1, 32'd0, 32'd14, 32'hFFFF8001);
    next_edge();
    check_output("lhu final_output", final_output, 32'h00008001);

    apply_stimulus(7'b0100011, 26, 32'd13, 32'h3ffff, 32'd1, 32'd0, 32'd14, 32'd0);
    next_edge();
    check_output("sw wr_en", {31'd0, wr_en}, 32'd1);
    check_output("sw addr", addr, 32'd14);
    check_output("sw mem_write", mem_write, 32'h3ffff);
    check_output("sw final_output", final_output, 32'd0);

    apply_stimulus(7'b0100011, 24, 32'd13, 32'h3ffff, 32'd1, 32'd0, 32'd14, 32'd0);
    next_edge();
    check_output("sb mem_write", mem_write, 32'hFF);

    apply_stimulus(7'b1100011, 27, 32'd13, 32'd13, 32'd8, 32'd10, 32'd0, 32'd0);
    check_output("beq instructions", {22'd0, instructions}, 32'h002);
    next_edge();
    check_output("beq j_signal", {31'd0, j_signal}, 32'd1);
    check_output("beq jump", jump, 32'd18);

    apply_stimulus(7'b1100011, 28, 32'd13, 32'd13, 32'd8, 32'd10, 32'd0, 32'd0);
    next_edge();
    check_output("bne j_signal", {31'd0, j_signal}, 32'd0);
    check_output("bne jump", jump, 32'd0);

    apply_stimulus(7'b1100011, 29, 32'hFFFFFFFF, 32'd1, 32'd8, 32'd10, 32'd0, 32'd0);
    next_edge();
    check_output("blt signed j_signal", {31'd0, j_signal}, 32'd1);

    apply_stimulus(7'b1100011, 31, 32'hFFFFFFFF, 32'd1, 32'd8, 32'd10, 32'd0, 32'd0);
    next_edge();
    check_output("bltu unsigned j_signal", {31'd0, j_signal}, 32'd0);

    apply_stimulus(7'b1101111, 35, 32'd0, 32'd0, 32'd8, 32'd10, 32'd18, 32'd0);
    check_output("jal v1", v1, 32'd10);
    next_edge();
    check_output("jal jump", jump, 32'd18);
    check_output("jal final_output", final_output, 32'd14);
    check_output("jal j_signal", {31'd0, j_signal}, 32'd1);

    apply_stimulus(7'b1100111, 36, 32'd10, 32'd0, 32'd1, 32'd10, 32'd11, 32'd0);
    next_edge();
    check_output("jalr jump", jump, 32'd10);
    check_output("jalr final_output", final_output, 32'd14);

    apply_stimulus(7'b0010011, 18, 32'd5, 32'd0, 32'd3, 32'd0, 32'd0, 32'd0);
    check_output("srai instructions", {22'd0, instructions}, 32'h080);
    check_output("srai v2", v2, 32'd3);

    apply_stimulus(7'b0110111, 33, 32'd5, 32'd0, 32'h12345000, 32'd0, 32'h12345000, 32'd0);
    check_output("lui v1", v1, 32'd0);
    next_edge();
    check_output("lui final_output", final_output, 32'h12345000);

    apply_stimulus(7'b1111111, 0, 32'd13, 32'd13, 32'd0, 32'd0, 32'd26, 32'd0);
    check_output("unknown instructions", {22'd0, instructions}, 32'd0);
    check_output("unknown v1", v1, 32'd0);
    next_edge();
    check_output("unknown final_output", final_output, 32'd0);

    apply_stimulus(7'b0110011, 19, 32'd13, 32'd13, 32'd0, 32'd0, 32'd26, 32'd0);
    check_output("bad bit instructions", {22'd0, instructions}, 32'd0);
    next_edge();
    check_output("bad bit final_output", final_output, 32'd0);

    // Mid-cycle reset pulse while registered outputs hold a nonzero result.
    apply_stimulus(7'b0100011, 26, 32'd13, 32'h55, 32'd1, 32'd0, 32'd14, 32'd0);
    next_edge();
    #2 rst = 1'b1;
    #1;
    check_output("midrst wr_en", {31'd0, wr_en}, 32'd0);
    check_output("midrst addr", addr, 32'd0);
    check_output("midrst mem_write", mem_write, 32'd0);
    check_output("midrst instructions", {22'd0, instructions}, 32'h001);
    @(negedge clk) rst = 1'b0;
    next_edge();
    check_output("recover mem_write", mem_write, 32'h55);
    check_output("recover wr_en", {31'd0, wr_en}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  in  1  single clock; all registered outputs update on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 opcode  in  7  RV32I major opcode.
REQ-004 out_signal  in  37  one-hot decoded instruction, bit map per REQ-013.
REQ-005 rs1_input, rs2_input  in  32 each  register operands.
REQ-006 imm  in  32  sign-extended immediate; branch/jump imm is the full byte offset.
REQ-007 pc_input  in  32  PC of current instruction.
REQ-008 mem_read  in  32  data word returned by memory for loads.
REQ-009 ALUoutput  in  32  result from external ALU, combinational response to v1/v2/instructions.
REQ-010 instructions  out  10  one-hot ALU op, combinational: bit0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and.
REQ-011 v1, v2  out  32 each  ALU operands, combinational.
REQ-012 Registered outputs: final_output 32 (writeback value), addr 32 (memory address), mem_write 32 (store data), wr_en 1 (memory write strobe), j_signal 1 (PC redirect), jump 32 (redirect target).

Function
REQ-013 out_signal bits: 0-9 add,sub,sll,slt,sltu,xor,srl,sra,or,and; 10-18 addi,slti,sltiu,xori,ori,andi,slli,srli,srai; 19-23 lb,lh,lw,lbu,lhu; 24-26 sb,sh,sw; 27-32 beq,bne,blt,bge,bltu,bgeu; 33 lui; 34 auipc; 35 jal; 36 jalr.
REQ-014 Class selected by opcode: 0110011 R, 0010011 I, 0000011 load, 0100011 store, 1100011 branch, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR.
REQ-015 Operands/op: R: v1=rs1,v2=rs2, op per bits 0-9; I: v1=rs1,v2=imm, matching op; load/store/JALR: v1=rs1,v2=imm, add; branch: v1=rs1,v2=rs2, sub; LUI: v1=0,v2=imm, add; AUIPC/JAL: v1=pc,v2=imm, add.
REQ-016 Unknown opcode, or no out_signal bit valid for the opcode class: instructions=0, v1=v2=0; registered outputs load 0 next edge.
REQ-017 final_output: R/I/LUI/AUIPC = ALUoutput; load = mem_read extended (lb sign-ext [7:0], lh sign-ext [15:0], lw full, lbu/lhu zero-ext); JAL/JALR = pc_input+4; store/branch = 0.
REQ-018 addr = ALUoutput for load/store, else 0.
REQ-019 Store: wr_en=1; mem_write = rs2 zero-extended [7:0] (sb), [15:0] (sh), full (sw). Non-store: wr_en=0, mem_write=0.
REQ-020 Branch condition computed internally from rs1/rs2 (signed for blt/bge, unsigned for bltu/bgeu); taken: j_signal=1, jump=pc_input+imm; not taken: j_signal=0, jump=0.
REQ-021 JAL: j_signal=1, jump=pc_input+imm. JALR: j_signal=1, jump=(rs1_input+imm) with bit0 cleared.
REQ-022 All adds wrap modulo 2^32.
REQ-023 Latency: registered outputs reflect inputs sampled at the rising edge (one cycle); inputs held stable produce stable outputs.

Reset
REQ-024 rst high: final_output, addr, mem_write, jump = 0; wr_en, j_signal = 0, immediately, regardless of clk.
REQ-025 Reset asserted mid-operation overrides any in-flight result; first edge after release loads values from current inputs.
REQ-026 Combinational outputs (instructions, v1, v2) unaffected by rst.

Structure
REQ-027 Shared package holds opcode constants, out_signal bit indices and ALU op one-hot encodings.
REQ-028 One sub-module natural: branch_compare (rs1, rs2, 6 branch bits -> taken); rest in control_unit.

Verification
REQ-029 add: opcode 0110011, out_signal bit0, rs1=rs2=13, ALUoutput=26 -> instructions=0x001, v1=v2=13; next edge final_output=26, wr_en=0, j_signal=0.
REQ-030 lw/lb: opcode 0000011, bit21, rs1=13, imm=1, ALUoutput=14, mem_read=0x3ffff -> addr=14, final_output=0x3ffff; bit19 with mem_read=0x80 -> final_output=0xFFFFFF80.
REQ-031 sw/sb: opcode 0100011, bit26, rs2=0x3ffff, ALUoutput=14 -> wr_en=1, addr=14, mem_write=0x3ffff; bit24 -> mem_write=0xFF.
REQ-032 beq: rs1=rs2=13, pc=10, imm=8 -> j_signal=1, jump=18; bne same inputs -> j_signal=0, jump=0.
REQ-033 jal pc=10 imm=8 -> jump=18, final_output=14; jalr rs1=10 imm=1 -> jump=10, final_output=14.
REQ-034 rst pulse between edges while outputs nonzero -> all registered outputs 0 immediately; recover on next edge after release.
